// File: rtl/sseg_pkg.sv
// ============================================================================
//  Module      : sseg_pkg
//  Description : Shared definitions for the memory-fed 7-segment scanner:
//                blank segment pattern, hex-to-segment decode and the fetch
//                state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sseg_pkg;

    // All seven segments off (active-low).
    localparam logic [6:0] SSEG_BLANK = 7'h7f;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        LAST = 2'd2,
        DONE = 2'd3
    } fetch_state_t;

    // Active-low segment pattern, bit order g..a.
    function automatic logic [6:0] hex2seg(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'h40;
            4'h1:    seg = 7'h79;
            4'h2:    seg = 7'h24;
            4'h3:    seg = 7'h30;
            4'h4:    seg = 7'h19;
            4'h5:    seg = 7'h12;
            4'h6:    seg = 7'h02;
            4'h7:    seg = 7'h78;
            4'h8:    seg = 7'h00;
            4'h9:    seg = 7'h10;
            4'ha:    seg = 7'h08;
            4'hb:    seg = 7'h03;
            4'hc:    seg = 7'h46;
            4'hd:    seg = 7'h21;
            4'he:    seg = 7'h06;
            default: seg = 7'h0e;
        endcase
        return seg;
    endfunction

endpackage

`default_nettype wire

// File: rtl/scan_timer.sv
// ============================================================================
//  Module      : scan_timer
//  Description : Refresh prescaler and digit index for a multiplexed display.
//                The digit index advances each time the DIV_W-bit prescaler
//                wraps. The anode output is registered from the current index
//                so it stays aligned with a segment register that is loaded
//                from the same index on the same edge.
//  Ports       : clk   - system clock
//                reset - asynchronous active-high reset
//                idx   - current digit index (0 = rightmost)
//                an    - registered one-hot-low digit enable
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module scan_timer #(
    parameter  int DIV_W  = 16,
    parameter  int DIGITS = 4,
    localparam int IDX_W  = $clog2(DIGITS)
) (
    input  logic              clk,
    input  logic              reset,
    output logic [IDX_W-1:0]  idx,
    output logic [DIGITS-1:0] an
);

    logic [DIV_W-1:0]  r_div;
    logic [IDX_W-1:0]  r_idx;
    logic [DIGITS-1:0] r_an;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_div <= '0;
            r_idx <= '0;
            r_an  <= '1;
        end else begin
            r_div <= r_div + DIV_W'(1);
            if (r_div == '1) begin
                r_idx <= (r_idx == IDX_W'(DIGITS - 1)) ? '0 : r_idx + IDX_W'(1);
            end
            r_an <= ~(DIGITS'(1) << r_idx);
        end
    end

    assign idx = r_idx;
    assign an  = r_an;

endmodule

`default_nettype wire

// File: rtl/mem_sseg_scan.sv
// ============================================================================
//  Module      : mem_sseg_scan
//  Description : On a start pulse, reads DIGITS/2 consecutive bytes from a
//                synchronous single-port memory into a shadow buffer, then
//                copies them atomically into the display buffer and drives a
//                multiplexed active-low 7-segment display in hex.
//  Ports       : clk, reset (async, active-high)
//                start, base_addr      - fetch request / first byte address
//                dp_mask               - live decimal-point enables
//                busy, done            - fetch status, done is a 1-cycle pulse
//                mem_addr, mem_rd      - memory read request
//                mem_rdata             - read data, valid the cycle after mem_rd
//                an, sseg              - registered digit enables / segments
//  Config      : LEADING_ZERO_BLANK_EN - blank digits above the most
//                significant nonzero nibble (digit 0 is never blanked)
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_sseg_scan
    import sseg_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DIGITS = 4,
    parameter int DIV_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [DIGITS-1:0] dp_mask,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [7:0]        mem_rdata,
    output logic [DIGITS-1:0] an,
    output logic [7:0]        sseg
);

    localparam int BYTES = DIGITS / 2;
    localparam int IDX_W = $clog2(DIGITS);
    localparam int CNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;

    fetch_state_t        r_state;
    logic [CNT_W-1:0]    r_rd_idx;      // index of the read currently on the bus
    logic [DIGITS*4-1:0] r_shadow;
    logic [DIGITS*4-1:0] r_disp;
    logic                r_busy;
    logic                r_done;
    logic                r_mem_rd;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [7:0]          r_sseg;

    logic [CNT_W-1:0]    w_cap_pos;
    logic [DIGITS*4-1:0] w_shadow_cap;
    logic [IDX_W-1:0]    w_idx;
    logic [3:0]          w_nib;
    logic                w_blank;
    logic [6:0]          w_seg;

    // Read data lags the request by one cycle, so while read k is on the bus
    // the byte arriving belongs to read k-1. In LAST no read is pending and
    // the final byte is the one arriving.
    assign w_cap_pos = (r_state == LAST) ? r_rd_idx : r_rd_idx - CNT_W'(1);

    always_comb begin
        w_shadow_cap = r_shadow;
        for (int b = 0; b < BYTES; b++) begin
            if (b == int'(w_cap_pos)) begin
                w_shadow_cap[b*8 +: 8] = mem_rdata;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_rd_idx   <= '0;
            r_shadow   <= '0;
            r_disp     <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_mem_rd   <= 1'b0;
            r_mem_addr <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state    <= READ;
                        r_busy     <= 1'b1;
                        r_mem_rd   <= 1'b1;
                        r_mem_addr <= base_addr;
                        r_rd_idx   <= '0;
                    end
                end
                READ: begin
                    if (r_rd_idx != '0) begin
                        r_shadow <= w_shadow_cap;
                    end
                    if (r_rd_idx == CNT_W'(BYTES - 1)) begin
                        r_state  <= LAST;
                        r_mem_rd <= 1'b0;
                    end else begin
                        r_rd_idx   <= r_rd_idx + CNT_W'(1);
                        r_mem_addr <= r_mem_addr + ADDR_W'(1);
                    end
                end
                LAST: begin
                    // Final byte goes straight into the display together with
                    // the rest of the shadow so the update is atomic.
                    r_shadow <= w_shadow_cap;
                    r_disp   <= w_shadow_cap;
                    r_busy   <= 1'b0;
                    r_done   <= 1'b1;
                    r_state  <= DONE;
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    scan_timer #(
        .DIV_W  (DIV_W),
        .DIGITS (DIGITS)
    ) u_scan_timer (
        .clk   (clk),
        .reset (reset),
        .idx   (w_idx),
        .an    (an)
    );

    assign w_nib = r_disp[int'(w_idx)*4 +: 4];

`ifdef LEADING_ZERO_BLANK_EN
    // A digit is a leading zero when it and every digit above it are zero.
    assign w_blank = (w_idx != '0) && ((r_disp >> (int'(w_idx) * 4)) == '0);
`else
    assign w_blank = 1'b0;
`endif

    assign w_seg = w_blank ? SSEG_BLANK : hex2seg(w_nib);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sseg <= 8'hff;
        end else begin
            r_sseg <= {~dp_mask[w_idx], w_seg};
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign mem_rd   = r_mem_rd;
    assign mem_addr = r_mem_addr;
    assign sseg     = r_sseg;

endmodule

`default_nettype wire

// File: tb/tb_mem_sseg_scan.sv
`default_nettype none

module tb_mem_sseg_scan;

    localparam int ADDR_W = 16;
    localparam int DIGITS = 4;
    localparam int DIV_W  = 2;
    localparam int BYTES  = DIGITS / 2;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] base_addr = '0;
    logic [DIGITS-1:0] dp_mask = '0;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd;
    logic [7:0]        mem_rdata = 8'h00;
    logic [DIGITS-1:0] an;
    logic [7:0]        sseg;

    int total = 0;
    int bad   = 0;
    logic [15:0] exp_val = 16'h0000;

    logic [7:0] mem [0:65535];

    mem_sseg_scan #(
        .ADDR_W (ADDR_W),
        .DIGITS (DIGITS),
        .DIV_W  (DIV_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .base_addr (base_addr),
        .dp_mask   (dp_mask),
        .busy      (busy),
        .done      (done),
        .mem_addr  (mem_addr),
        .mem_rd    (mem_rd),
        .mem_rdata (mem_rdata),
        .an        (an),
        .sseg      (sseg)
    );

    always #5 clk = ~clk;

    // Synchronous memory: data for the address presented now appears next cycle.
    always @(posedge clk) mem_rdata <= mem[mem_addr];

    function automatic logic [6:0] seg_of(input logic [3:0] n);
        case (n)
            4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
            4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
            4'h8: return 7'h00;  4'h9: return 7'h10;  4'ha: return 7'h08;  4'hb: return 7'h03;
            4'hc: return 7'h46;  4'hd: return 7'h21;  4'he: return 7'h06;  default: return 7'h0e;
        endcase
    endfunction

    // Expected segment byte for digit i of displayed value v.
    function automatic logic [7:0] exp_sseg(input logic [15:0] v, input logic [3:0] dp, input int i);
        logic [6:0] s;
        s = seg_of(4'((v >> (4 * i)) & 16'h000f));
`ifdef LEADING_ZERO_BLANK_EN
        if (i > 0 && (v >> (4 * i)) == 16'h0000) s = 7'h7f;
`endif
        return {~dp[i], s};
    endfunction

    // Watch the scan for 20 cycles; every digit must appear with the expected pattern.
    task automatic check_display(input string name);
        int seen;
        int d;
        seen = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            d = -1;
            for (int i = 0; i < DIGITS; i++) if (an == ~(4'b0001 << i)) d = i;
            total++;
            if (d < 0) begin
                bad++;
                $display("FAIL %s an_onehot: got %b want one-hot-low", name, an);
            end else begin
                seen |= (1 << d);
                total++;
                if (sseg !== exp_sseg(exp_val, dp_mask, d)) begin
                    bad++;
                    $display("FAIL %s sseg digit %0d: got %h want %h", name, d, sseg,
                             exp_sseg(exp_val, dp_mask, d));
                end
            end
        end
        total++;
        if (seen != 15) begin
            bad++;
            $display("FAIL %s digits_seen: got %b want 1111", name, 4'(seen));
        end
    endtask

    // One fetch; checks the per-cycle handshake against the cycle numbering.
    task automatic run_fetch(input logic [15:0] base, input logic [7:0] b0, input logic [7:0] b1,
                             input bit repulse, input string name);
        int dones;
        logic [15:0] a1;
        logic [15:0] ea;
        a1 = base + 16'd1;
        mem[base] = b0;
        mem[a1]   = b1;
        dones = 0;
        @(negedge clk);
        start = 1'b1;
        base_addr = base;
        for (int c = 1; c <= BYTES + 4; c++) begin
            @(negedge clk);
            start = repulse && (c <= 3);
            base_addr = 16'($urandom);
            total++;
            if (mem_rd !== (c <= BYTES)) begin
                bad++;
                $display("FAIL %s mem_rd cycle %0d: got %b want %b", name, c, mem_rd, (c <= BYTES));
            end
            if (c <= BYTES) begin
                ea = base + 16'(c - 1);
                total++;
                if (mem_addr !== ea) begin
                    bad++;
                    $display("FAIL %s mem_addr cycle %0d: got %h want %h", name, c, mem_addr, ea);
                end
            end
            total++;
            if (busy !== (c <= BYTES + 1)) begin
                bad++;
                $display("FAIL %s busy cycle %0d: got %b want %b", name, c, busy, (c <= BYTES + 1));
            end
            total++;
            if (done !== (c == BYTES + 2)) begin
                bad++;
                $display("FAIL %s done cycle %0d: got %b want %b", name, c, done, (c == BYTES + 2));
            end
            if (done === 1'b1) dones++;
        end
        start = 1'b0;
        total++;
        if (dones != 1) begin
            bad++;
            $display("FAIL %s done_count: got %0d want 1", name, dones);
        end
        exp_val = {b1, b0};
    endtask

    task automatic check_reset_values(input string name);
        total++;
        if ({busy, done, mem_rd} !== 3'b000 || mem_addr !== 16'h0000 || an !== 4'hf || sseg !== 8'hff) begin
            bad++;
            $display("FAIL %s reset_values: got busy=%b done=%b rd=%b addr=%h an=%b sseg=%h want 0 0 0 0000 1111 ff",
                     name, busy, done, mem_rd, mem_addr, an, sseg);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        dp_mask = 4'b0011;
        repeat (2) @(negedge clk);
        check_reset_values("reset");
        reset = 1'b0;
        exp_val = 16'h0000;
        @(negedge clk);
        total++;
        if (an !== 4'b1110 || sseg !== exp_sseg(16'h0000, dp_mask, 0)) begin
            bad++;
            $display("FAIL reset first_scan: got an=%b sseg=%h want 1110 %h", an, sseg,
                     exp_sseg(16'h0000, dp_mask, 0));
        end
    endtask

    task automatic test_basic();
        dp_mask = 4'b0000;
        run_fetch(16'h0010, 8'h3a, 8'hed, 1'b0, "basic");
        check_display("basic");
    endtask

    task automatic test_wrap();
        dp_mask = 4'b1000;
        run_fetch(16'hffff, 8'h71, 8'hc4, 1'b0, "wrap");
        check_display("wrap");
    endtask

    task automatic test_repulse();
        dp_mask = 4'b0101;
        run_fetch(16'h1234, 8'h9b, 8'h20, 1'b1, "repulse");
        check_display("repulse");
    endtask

    task automatic test_reset_midfetch();
        int dones;
        mem[16'h0200] = 8'h5c;
        mem[16'h0201] = 8'ha7;
        @(negedge clk);
        start = 1'b1;
        base_addr = 16'h0200;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_reset_values("midfetch");
        @(negedge clk);
        reset = 1'b0;
        dones = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (done === 1'b1) dones++;
        end
        total++;
        if (dones != 0) begin
            bad++;
            $display("FAIL midfetch stray_done: got %0d want 0", dones);
        end
        exp_val = 16'h0000;
        check_display("midfetch_cleared");
        run_fetch(16'h0200, 8'h5c, 8'ha7, 1'b0, "after_reset");
        check_display("after_reset");
    endtask

    task automatic test_scan();
        logic [3:0] ea;
        logic       edp;
        dp_mask = 4'b0100;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        exp_val = 16'h0000;
        for (int j = 0; j < 16; j++) begin
            @(negedge clk);
            ea  = ~(4'b0001 << (j / 4));
            edp = (j / 4 == 2) ? 1'b0 : 1'b1;
            total++;
            if (an !== ea || sseg[7] !== edp) begin
                bad++;
                $display("FAIL scan cycle %0d: got an=%b dp=%b want an=%b dp=%b", j, an, sseg[7], ea, edp);
            end
        end
    endtask

    task automatic test_blank();
        dp_mask = 4'b0010;
        run_fetch(16'h0400, 8'h05, 8'h00, 1'b0, "blank");
        check_display("blank");
    endtask

    task automatic test_random();
        for (int n = 0; n < 6; n++) begin
            dp_mask = 4'($urandom);
            run_fetch(16'($urandom), 8'($urandom), 8'($urandom), 1'($urandom), "random");
            check_display("random");
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_repulse();
        test_reset_midfetch();
        test_scan();
        test_blank();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
